// File: rtl/apb_mem_slave_param_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_param_if
//
// Bus bundle for the parametrised APB memory slave. It carries the APB3/APB4
// style setup/access handshake between one bus master and one slave.
//
// Signals:
//   address      byte address (PADDR)
//   select       slave select (PSEL)
//   enable       access phase (PENABLE)
//   write_en     1 = write, 0 = read (PWRITE)
//   write_data   write data (PWDATA)
//   strobe       byte-lane write enables (PSTRB)
//   ready        transfer complete (PREADY)
//   slave_error  transfer error (PSLVERR), meaningful only while ready=1
//   read_data    read data (PRDATA), meaningful only while ready=1
//
// Modports:
//   master  drives the request side and observes the response
//   slave   observes the request side and drives the response
// ---------------------------------------------------------------------------
interface apb_mem_slave_param_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   address;
  logic                    select;
  logic                    enable;
  logic                    write_en;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic                    ready;
  logic                    slave_error;
  logic [DATA_WIDTH-1:0]   read_data;

  modport master (
    output address, select, enable, write_en, write_data, strobe,
    input  ready, slave_error, read_data
  );

  modport slave (
    input  address, select, enable, write_en, write_data, strobe,
    output ready, slave_error, read_data
  );

endinterface

// File: rtl/apb_mem_slave_param.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_param
//
// Parametrised APB memory-mapped slave: a word-addressed storage array of
// DEPTH words of DATA_WIDTH bits, mapped at BASE_ADDR, behind the APB
// setup/access handshake. Each transfer takes one setup cycle, WAIT_STATES
// ready-low cycles and one access cycle. Writes honour byte strobes.
// Out-of-range or misaligned accesses complete with slave_error=1 and never
// touch the array.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   bus     slave modport of apb_mem_slave_param_if (address, select,
//           enable, write_en, write_data, strobe in; ready, slave_error,
//           read_data out)
//
// Parameters:
//   DATA_WIDTH   data bus width in bits, multiple of 8, >= 8
//   ADDR_WIDTH   byte address width
//   DEPTH        number of words, power of 2, >= 2
//   BASE_ADDR    byte address of word 0, aligned to DATA_WIDTH/8
//   WAIT_STATES  ready-low cycles per transfer, 0..15
//
// Build option:
//   APB_MEM_CLEAR_ON_RESET_EN  when defined, every word is cleared to zero on
//                              a reset edge; otherwise the array keeps its
//                              contents across reset.
// ---------------------------------------------------------------------------
module apb_mem_slave_param #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input logic                  clock,
  input logic                  reset,
  apb_mem_slave_param_if.slave bus
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  // Low address bits that must be zero for a word-aligned access; empty
  // (all zero) for an 8-bit data bus, where every byte address is aligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  // With no wait states the setup phase goes straight to the access phase.
  localparam state_t FIRST_STATE = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;

  state_t state;
  state_t state_next;
  logic [3:0] count;
  logic [3:0] count_next;

  // Request attributes captured in the setup phase; later changes on the bus
  // are deliberately ignored for the rest of the transfer.
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic [LANES-1:0] strobe_q;
  logic             err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Address decode for the setup phase
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  setup_err;

  always_comb begin
    // The subtraction wraps for addresses below BASE_ADDR; that case is
    // flagged separately so the wrapped offset is never used.
    offset    = bus.address - BASE_ADDR;
    word_idx  = offset >> LSB;
    setup_err = (bus.address < BASE_ADDR)
             || (word_idx >= ADDR_WIDTH'(DEPTH))
             || ((offset & ALIGN_MASK) != '0);
  end

  logic setup_phase;
  logic access_phase;

  assign setup_phase  = bus.select & ~bus.enable;
  assign access_phase = bus.select &  bus.enable;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  logic latch_en;
  logic ready_c;
  logic do_write;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    count_next = count;
    latch_en   = 1'b0;
    ready_c    = 1'b0;
    do_write   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (setup_phase) begin
          latch_en   = 1'b1;
          count_next = WAIT_LOAD;
          state_next = FIRST_STATE;
        end
      end

      ST_WAIT: begin
        if (access_phase) begin
          count_next = count - 4'd1;
          // The cycle that consumes the last wait state hands over to the
          // access cycle, giving exactly WAIT_STATES ready-low cycles.
          if (count == 4'd1) begin
            state_next = ST_ACCESS;
          end
        end else begin
          // Master dropped the transfer: abandon it without writing.
          state_next = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        ready_c    = access_phase;
        do_write   = access_phase & write_q & ~err_q;
        // Returning to IDLE lets a setup phase in the very next cycle start
        // the following transfer with no gap.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.ready       = ready_c;
  assign bus.slave_error = ready_c & err_q;
  assign bus.read_data   = (ready_c && !err_q && !write_q) ? mem[idx_q] : '0;

  // -------------------------------------------------------------------------
  // State register and request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (latch_en) begin
        idx_q    <= word_idx[IDX_W-1:0];
        write_q  <= bus.write_en;
        strobe_q <= bus.strobe;
        err_q    <= setup_err;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Storage array
  // -------------------------------------------------------------------------
`ifdef APB_MEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      for (int b = 0; b < LANES; b++) begin
        if (strobe_q[b]) begin
          mem[idx_q][b*8 +: 8] <= bus.write_data[b*8 +: 8];
        end
      end
    end
  end
`else
  // NOTE: the array has no reset term so it can map onto plain RAM; only the
  // write is blocked while reset is high, so a reset edge never stores data.
  always_ff @(posedge clock) begin
    if (!reset && do_write) begin
      for (int b = 0; b < LANES; b++) begin
        if (strobe_q[b]) begin
          mem[idx_q][b*8 +: 8] <= bus.write_data[b*8 +: 8];
        end
      end
    end
  end
`endif

endmodule
